mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage fed directly by the EXE/MEM register. Holds a word-addressed data
//   memory with a configurable access latency, and stalls the front of the pipe while an
//   access is in flight. Resolves branches and registers results into the MEM/WB outputs.
// PARAMETERS
//   MEM_AW   8  data memory word-address width (2**MEM_AW words of 32 bits)
//   MEM_LAT  2  extra cycles per load/store, 0..15 (0 = single-cycle access)
// PORTS
//   clk              in   1   clock, all state updates on rising edge
//   rst              in   1   asynchronous, active-low reset
//   WB_In            in   2   [1]=RegWrite [0]=MemToReg, passed through to WB
//   M_In             in   3   [2]=Branch [1]=MemRead [0]=MemWrite
//   zeroIn           in   1   ALU zero flag
//   PC_In            in   32  branch target computed in EXE
//   ALUResIn         in   32  ALU result / memory byte address
//   readDate2In      in   32  store data
//   destIn           in   5   destination register
//   WB_Out           out  2   registered WB controls
//   readDataOut      out  32  registered load data
//   ALUResOut        out  32  registered ALU result
//   destOut          out  5   registered destination
//   PCSrc            out  1   comb: M_In[2] & zeroIn
//   branchTargetOut  out  32  comb: PC_In
//   stall            out  1   comb: hold PC, IF/ID, ID/EXE, EXE/MEM this cycle
// BEHAVIOUR
//   - Reset (rst=0, async): all registered outputs 0, state IDLE, wait counter cnt=0.
//     Memory array is not cleared; contents survive reset.
//   - acc = M_In[1] | M_In[0]. Word index = ALUResIn[MEM_AW+1:2]; ALUResIn[1:0] ignored.
//   - FSM IDLE/WAIT, 4-bit cnt:
//     IDLE: acc & MEM_LAT>0 -> stall=1, cnt<=1, go WAIT. acc & MEM_LAT==0 -> complete now.
//     WAIT: stall = (cnt != MEM_LAT). cnt<MEM_LAT -> cnt<=cnt+1.
//       cnt==MEM_LAT -> stall=0, complete, cnt<=0, go IDLE.
//   - Completion edge (only one per access): a store writes readDate2In to mem[index].
//     A load latches mem[index] into readDataOut. The MEM/WB outputs load from the inputs.
//   - Stall cycles: WB_Out<=0 (bubble into WB). Other MEM/WB outputs hold.
//     Memory is not written during stall cycles.
//   - Non-access instructions: one cycle, no stall; readDataOut<=0.
//   - Total load/store occupancy MEM_LAT+1 cycles. Upstream must hold all inputs stable while stall=1.
//   - MemRead & MemWrite both set: treated as a store; readDataOut<=0.
//   - Branch with acc set: PCSrc still comb from the inputs, valid every cycle.
//   - Reset during WAIT: access abandoned, no memory write, stall drops immediately.
//   - Load after store to the same word returns the stored value.
//     The write commits before the load's completion edge.
// CONFIGURATION
//   MEM_STAGE_ALIGN_CHK_EN defined: extra output misalignOut (1 bit, reset 0).
//     It is registered at completion: acc & (ALUResIn[1:0]!=0).
//     A misaligned store does not write memory; a misaligned load returns 0.
//     No extra stall cycles.
//   Not defined: no misalignOut port; low address bits ignored, access proceeds normally.
// TESTING
//   1. Reset, MEM_LAT=2: store 0xDEADBEEF to addr 0x10 -> stall=1 for 2 cycles, 0 on 3rd.
//      mem[4]=0xDEADBEEF after the 3rd edge, WB_Out=0 during the stall cycles.
//   2. Load from 0x10 next -> stall 2 cycles; readDataOut=0xDEADBEEF after 3rd edge, WB_Out=WB_In.
//   3. ALU op (M_In=0, WB_In=2'b10, destIn=7, ALUResIn=5) -> no stall.
//      Next edge: WB_Out=2'b10, destOut=7, ALUResOut=5.
//   4. M_In=3'b100, zeroIn=1, PC_In=0x40 -> PCSrc=1, branchTargetOut=0x40 same cycle, no stall.
//   5. Store 0x1234 to 0x20, rst=0 after 1 stall cycle -> outputs 0, stall=0, mem[8] unchanged.
//   6. ALIGN_CHK_EN: store to 0x22 -> misalignOut=1 at completion, mem[8] unchanged.
//      MEM_LAT=0 build: load completes in 1 cycle with stall never asserted.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM pipeline stage. Holds a word-addressed 32-bit data memory
//             with a configurable access latency, and stalls the front of the
//             pipe while a load or store is in flight. It also resolves
//             branches and registers results into the MEM/WB outputs.
//  Params   : MEM_AW  - data memory word-address width (2**MEM_AW words)
//             MEM_LAT - extra cycles per load/store, 0..15 (0 = single cycle)
//  Ports    : clk, rst (async, active-low)
//             WB_In[1:0]   {RegWrite, MemToReg}, passed through to WB
//             M_In[2:0]    {Branch, MemRead, MemWrite}
//             zeroIn       ALU zero flag
//             PC_In        branch target from EXE
//             ALUResIn     ALU result / memory byte address
//             readDate2In  store data
//             destIn       destination register
//             WB_Out, readDataOut, ALUResOut, destOut : registered MEM/WB
//             PCSrc, branchTargetOut                  : combinational branch
//             stall        : hold PC, IF/ID, ID/EXE, EXE/MEM this cycle
//  Options  : MEM_STAGE_ALIGN_CHK_EN - adds misalignOut; a misaligned store
//             does not write memory and a misaligned load returns 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int MEM_AW  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_In,
    input  logic [2:0]  M_In,
    input  logic        zeroIn,
    input  logic [31:0] PC_In,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] readDate2In,
    input  logic [4:0]  destIn,
    output logic [1:0]  WB_Out,
    output logic [31:0] readDataOut,
    output logic [31:0] ALUResOut,
    output logic [4:0]  destOut,
    output logic        PCSrc,
    output logic [31:0] branchTargetOut,
    output logic        stall
`ifdef MEM_STAGE_ALIGN_CHK_EN
    ,
    output logic        misalignOut
`endif
);

    localparam logic [3:0] c_lat   = 4'(MEM_LAT);
    localparam int         c_depth = 1 << MEM_AW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mem [c_depth];

    logic               w_acc;
    logic               w_store;
    logic               w_load;
    logic               w_misalign;
    logic               w_mem_we;
    logic [MEM_AW-1:0]  w_idx;

    assign w_acc   = M_In[1] | M_In[0];
    // MemRead together with MemWrite is a store.
    assign w_store = M_In[0];
    assign w_load  = M_In[1] & ~M_In[0];
    assign w_idx   = ALUResIn[MEM_AW+1:2];

`ifdef MEM_STAGE_ALIGN_CHK_EN
    assign w_misalign = w_acc & (ALUResIn[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Branch resolution is independent of any memory access in flight.
    assign PCSrc           = M_In[2] & zeroIn;
    assign branchTargetOut = PC_In;

    // Stall is gated by reset so an abandoned access releases the pipe at once.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (r_state == S_IDLE) begin
                stall = w_acc & (c_lat != 4'd0);
            end else begin
                stall = (r_cnt != c_lat);
            end
        end
    end

    // An access completes on the first non-stalled edge; with inputs held
    // stable this happens exactly once per access.
    assign w_mem_we = rst & w_store & ~stall & ~w_misalign;

    // Latency FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && (c_lat != 4'd0)) begin
                        r_cnt   <= 4'd1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != c_lat) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data memory: not reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= readDate2In;
        end
    end

    // MEM/WB register: bubble into WB while stalled, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_Out      <= 2'b00;
            readDataOut <= 32'd0;
            ALUResOut   <= 32'd0;
            destOut     <= 5'd0;
        end else if (stall) begin
            WB_Out <= 2'b00;
        end else begin
            WB_Out      <= WB_In;
            readDataOut <= (w_load & ~w_misalign) ? r_mem[w_idx] : 32'd0;
            ALUResOut   <= ALUResIn;
            destOut     <= destIn;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalignOut <= 1'b0;
        end else if (!stall) begin
            misalignOut <= w_misalign;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage (MEM_LAT=2 main instance plus
//             a MEM_LAT=0 instance). Expected MEM/WB results are queued when
//             an operation is driven and compared when it completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int AW  = 8;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  WB_In = '0;
    logic [2:0]  M_In = '0;
    logic        zeroIn = 1'b0;
    logic [31:0] PC_In = '0;
    logic [31:0] ALUResIn = '0;
    logic [31:0] readDate2In = '0;
    logic [4:0]  destIn = '0;
    logic [1:0]  WB_Out;
    logic [31:0] readDataOut;
    logic [31:0] ALUResOut;
    logic [4:0]  destOut;
    logic        PCSrc;
    logic [31:0] branchTargetOut;
    logic        stall;
    logic        misalignOut;

    logic [1:0]  WB_In0 = '0;
    logic [2:0]  M_In0 = '0;
    logic [31:0] ALUResIn0 = '0;
    logic [31:0] readDate2In0 = '0;
    logic [1:0]  WB_Out0;
    logic [31:0] readDataOut0;
    logic [31:0] ALUResOut0;
    logic [4:0]  destOut0;
    logic        PCSrc0;
    logic [31:0] branchTargetOut0;
    logic        stall0;
    logic        misalignOut0;

    always #5 clk = ~clk;

    mem_stage #(.MEM_AW(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .WB_In(WB_In), .M_In(M_In), .zeroIn(zeroIn),
        .PC_In(PC_In), .ALUResIn(ALUResIn), .readDate2In(readDate2In),
        .destIn(destIn), .WB_Out(WB_Out), .readDataOut(readDataOut),
        .ALUResOut(ALUResOut), .destOut(destOut), .PCSrc(PCSrc),
        .branchTargetOut(branchTargetOut), .stall(stall)
`ifdef MEM_STAGE_ALIGN_CHK_EN
        , .misalignOut(misalignOut)
`endif
    );

    mem_stage #(.MEM_AW(AW), .MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .WB_In(WB_In0), .M_In(M_In0), .zeroIn(1'b0),
        .PC_In(32'd0), .ALUResIn(ALUResIn0), .readDate2In(readDate2In0),
        .destIn(5'd3), .WB_Out(WB_Out0), .readDataOut(readDataOut0),
        .ALUResOut(ALUResOut0), .destOut(destOut0), .PCSrc(PCSrc0),
        .branchTargetOut(branchTargetOut0), .stall(stall0)
`ifdef MEM_STAGE_ALIGN_CHK_EN
        , .misalignOut(misalignOut0)
`endif
    );

`ifndef MEM_STAGE_ALIGN_CHK_EN
    assign misalignOut  = 1'b0;
    assign misalignOut0 = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    int          total = 0;
    int          bad   = 0;

    // Drive one instruction, follow its stall cycles, then check MEM/WB.
    task automatic run_op(input logic [1:0] wb, input logic [2:0] m,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] dst);
        exp_t e;
        exp_t g;
        int   idx;
        int   n;
        int   n_exp;
        logic acc;
        logic mis;
        acc = m[1] | m[0];
        idx = int'(addr[AW+1:2]);
        mis = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHK_EN
        mis = acc & (addr[1:0] != 2'b00);
`endif
        e.wb = wb; e.alu = addr; e.dst = dst; e.rd = 32'd0; e.mis = mis;
        if (m[0]) begin
            if (!mis) mdl[idx] = wd;
        end else if (m[1] && !mis) begin
            e.rd = mdl.exists(idx) ? mdl[idx] : 32'd0;
        end
        sb.push_back(e);
        n_exp = acc ? LAT : 0;
        @(negedge clk);
        WB_In = wb; M_In = m; ALUResIn = addr; readDate2In = wd; destIn = dst;
        #1;
        n = 0;
        while (stall === 1'b1 && n <= LAT + 4) begin
            @(posedge clk); #1;
            n++;
            total++;
            if (WB_Out !== 2'b00) begin
                bad++;
                $display("FAIL bubble WB_Out got=%b exp=00", WB_Out);
            end
        end
        total++;
        if (n !== n_exp) begin
            bad++;
            $display("FAIL stall_cycles addr=%h got=%0d exp=%0d", addr, n, n_exp);
        end
        @(posedge clk); #1;
        g = sb.pop_front();
        total++;
        if (WB_Out !== g.wb) begin
            bad++; $display("FAIL WB_Out got=%b exp=%b", WB_Out, g.wb);
        end
        total++;
        if (readDataOut !== g.rd) begin
            bad++; $display("FAIL readDataOut addr=%h got=%h exp=%h", addr, readDataOut, g.rd);
        end
        total++;
        if (ALUResOut !== g.alu) begin
            bad++; $display("FAIL ALUResOut got=%h exp=%h", ALUResOut, g.alu);
        end
        total++;
        if (destOut !== g.dst) begin
            bad++; $display("FAIL destOut got=%0d exp=%0d", destOut, g.dst);
        end
        total++;
        if (misalignOut !== g.mis) begin
            bad++; $display("FAIL misalignOut got=%b exp=%b", misalignOut, g.mis);
        end
    endtask

    task automatic test_reset;
        M_In = 3'b001;   // a pending store must not stall while in reset
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({WB_Out, readDataOut, ALUResOut, destOut, misalignOut} !== 72'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {WB_Out, readDataOut, ALUResOut, destOut, misalignOut});
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        @(negedge clk); M_In = 3'b000;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_store_load;
        run_op(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
        run_op(2'b11, 3'b010, 32'h10, 32'h0, 5'd12);
    endtask

    task automatic test_alu;
        run_op(2'b10, 3'b000, 32'd5, 32'h0, 5'd7);
    endtask

    task automatic test_branch;
        @(negedge clk);
        WB_In = 2'b00; M_In = 3'b100; zeroIn = 1'b1; PC_In = 32'h40; ALUResIn = 32'h0;
        #1;
        total++;
        if (PCSrc !== 1'b1 || branchTargetOut !== 32'h40 || stall !== 1'b0) begin
            bad++;
            $display("FAIL branch_taken got=%b/%h/%b exp=1/00000040/0", PCSrc, branchTargetOut, stall);
        end
        zeroIn = 1'b0; #1;
        total++;
        if (PCSrc !== 1'b0) begin
            bad++; $display("FAIL branch_not_taken got=%b exp=0", PCSrc);
        end
        M_In = 3'b110; zeroIn = 1'b1; #1;
        total++;
        if (PCSrc !== 1'b1 || stall !== 1'b1) begin
            bad++; $display("FAIL branch_with_load got=%b/%b exp=1/1", PCSrc, stall);
        end
        M_In = 3'b100; #1;
        @(posedge clk); #1;
        zeroIn = 1'b0;
    endtask

    task automatic test_reset_abort;
        run_op(2'b10, 3'b001, 32'h20, 32'h5555AAAA, 5'd3);
        @(negedge clk);
        WB_In = 2'b11; M_In = 3'b001; ALUResIn = 32'h20; readDate2In = 32'h1234; destIn = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL abort_stall_start got=%b exp=1", stall);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL abort_stall_drop got=%b exp=0", stall);
        end
        total++;
        if ({WB_Out, readDataOut, ALUResOut, destOut} !== 71'd0) begin
            bad++;
            $display("FAIL abort_outputs got=%h exp=0", {WB_Out, readDataOut, ALUResOut, destOut});
        end
        @(negedge clk); M_In = 3'b000;
        @(negedge clk); rst = 1'b1;
        run_op(2'b10, 3'b010, 32'h20, 32'h0, 5'd4);
    endtask

    task automatic test_low_bits;
        run_op(2'b00, 3'b001, 32'h22, 32'h0BADF00D, 5'd0);
        run_op(2'b11, 3'b010, 32'h20, 32'h0, 5'd5);
        run_op(2'b11, 3'b010, 32'h22, 32'h0, 5'd6);
    endtask

    task automatic test_read_write_both;
        run_op(2'b11, 3'b011, 32'h30, 32'h0000CAFE, 5'd8);
        run_op(2'b11, 3'b010, 32'h30, 32'h0, 5'd8);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            d = $urandom;
            run_op(2'b00, 3'b001, a, d, 5'(i));
            run_op(2'b11, 3'b010, a, 32'h0, 5'(i + 10));
            run_op(2'b10, 3'b000, d, 32'h0, 5'(i + 20));
        end
    endtask

    task automatic test_lat0;
        @(negedge clk);
        WB_In0 = 2'b00; M_In0 = 3'b001; ALUResIn0 = 32'h10; readDate2In0 = 32'h77;
        #1;
        total++;
        if (stall0 !== 1'b0) begin
            bad++; $display("FAIL lat0_store_stall got=%b exp=0", stall0);
        end
        @(negedge clk);
        WB_In0 = 2'b11; M_In0 = 3'b010; readDate2In0 = 32'h0;
        #1;
        total++;
        if (stall0 !== 1'b0) begin
            bad++; $display("FAIL lat0_load_stall got=%b exp=0", stall0);
        end
        @(posedge clk); #1;
        total++;
        if (readDataOut0 !== 32'h77 || WB_Out0 !== 2'b11) begin
            bad++; $display("FAIL lat0_load got=%h/%b exp=00000077/11", readDataOut0, WB_Out0);
        end
        @(negedge clk); M_In0 = 3'b000;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_alu();
        test_branch();
        test_reset_abort();
        test_low_bits();
        test_read_write_both();
        test_back_to_back();
        test_lat0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
